// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: register-address width and the operand-mux
// select encoding that both this unit and the EX operand muxes decode.
package riscv_pipe_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_MEMWB   = 2'b01,
        FWD_EXMEM   = 2'b10
    } fwd_sel_e;

endpackage : riscv_pipe_pkg

// File: rtl/fwd_sel_compare.sv
// Priority compare for one EX operand: the younger EX/MEM result wins over
// MEM/WB, and writes to x0 never forward.
module fwd_sel_compare
    import riscv_pipe_pkg::*;
#(
    parameter int REG_AW = riscv_pipe_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we,
    output logic [1:0]        sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_we && (mem_rd != '0) && (mem_rd == rs);
    assign wb_hit  = wb_we  && (wb_rd  != '0) && (wb_rd  == rs);

    always_comb begin
        sel = FWD_REGFILE;
        if (mem_hit) begin
            sel = FWD_EXMEM;
        end else if (wb_hit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule : fwd_sel_compare

// File: rtl/forward_hazard_unit.sv
// EX-stage forwarding select generation and load-use stall detection, with
// private shadows of the EX/MEM and MEM/WB destination fields.
module forward_hazard_unit
    import riscv_pipe_pkg::*;
#(
    parameter int REG_AW = riscv_pipe_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              flush_ex,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [REG_AW-1:0] mem_rd_reg;
    logic              mem_we_reg;
    logic [REG_AW-1:0] wb_rd_reg;
    logic              wb_we_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic [CNT_W-1:0]  stall_cnt_next;

    logic [REG_AW-1:0] rs_vec  [2];
    logic [1:0]        sel_vec [2];

    assign rs_vec[0] = ex_rs1;
    assign rs_vec[1] = ex_rs2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
        fwd_sel_compare #(
            .REG_AW (REG_AW)
        ) u_cmp (
            .rs     (rs_vec[gi]),
            .mem_rd (mem_rd_reg),
            .mem_we (mem_we_reg),
            .wb_rd  (wb_rd_reg),
            .wb_we  (wb_we_reg),
            .sel    (sel_vec[gi])
        );
    end

    assign fwd_a_sel = sel_vec[0];
    assign fwd_b_sel = sel_vec[1];

    // A killed load cannot create a hazard; upstream turns stall into a bubble,
    // so this naturally lasts one cycle per load-use pair.
    assign stall = ex_valid && ex_memread && !flush_ex && (ex_rd != '0) &&
                   id_valid && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stall && !hold && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_rd_reg    <= '0;
            mem_we_reg    <= 1'b0;
            wb_rd_reg     <= '0;
            wb_we_reg     <= 1'b0;
            stall_cnt_reg <= '0;
        end else if (!hold) begin
            mem_rd_reg    <= ex_rd;
            mem_we_reg    <= ex_regwrite && ex_valid && !flush_ex;
            wb_rd_reg     <= mem_rd_reg;
            wb_we_reg     <= mem_we_reg;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule : forward_hazard_unit
